// File: rtl/harness_pkg.sv
// harness_pkg: state encoding, defaults and status layout shared by the program harness
package harness_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        HOLD,
        RUN,
        DONE
    } state_t;

    // a7 value the RV32I exit syscall leaves in place
    localparam int unsigned EXIT_A7_DEFAULT = 93;

    // Bit positions inside the packed result/status register
    localparam int unsigned ST_PASS     = 0;
    localparam int unsigned ST_TIMEOUT  = 1;
    localparam int unsigned ST_OVERFLOW = 2;
    localparam int unsigned ST_N        = 3;

    // Width able to hold 0..max inclusive, never narrower than one bit
    function automatic int unsigned cnt_w(input int unsigned max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that stops at MAX, with synchronous clear
module sat_counter
    import harness_pkg::*;
#(
    parameter  int unsigned MAX = 1,
    localparam int unsigned W   = cnt_w(MAX)
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clear_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o,
    output logic         at_max_o
);

    logic [W-1:0] count_q, count_d;

    assign at_max_o = count_q == W'(MAX);
    assign count_o  = count_q;

    // clear wins over increment; the count never passes MAX
    always_comb count_d = clear_i ? '0 : (inc_i && !at_max_o) ? count_q + 1'b1 : count_q;

    // count register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) count_q <= '0;
        else         count_q <= count_d;
    end

endmodule

// File: rtl/program_harness_ctrl.sv
// program_harness_ctrl: preloads a program into the core, runs it and reports pass/fail/timeout
module program_harness_ctrl
    import harness_pkg::*;
#(
    parameter  int unsigned WIDTH          = 32,
    parameter  int unsigned DEPTH          = 1024,
    parameter  int unsigned BASE_ADDR      = 0,
    parameter  int unsigned RESET_CYCLES   = 2,
    parameter  int unsigned TIMEOUT_CYCLES = 20000,
    parameter  int unsigned EXIT_A7        = EXIT_A7_DEFAULT,
    parameter  int unsigned SETTLE_CYCLES  = 4,
    localparam int unsigned WW             = cnt_w(DEPTH),
    localparam int unsigned CW             = cnt_w(TIMEOUT_CYCLES)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_last_i,
    output logic             in_ready_o,
    output logic             cpu_reset_o,
    output logic             mem_en_o,
    output logic [WIDTH-1:0] mem_data_o,
    output logic [WIDTH-1:0] mem_addr_o,
    input  logic [WIDTH-1:0] gp_i,
    input  logic [WIDTH-1:0] a7_i,
    input  logic [WIDTH-1:0] a0_i,
    output logic             done_o,
    output logic             pass_o,
    output logic             timeout_o,
    output logic             overflow_o,
    output logic [WW-1:0]    words_o,
    output logic [CW-1:0]    cycles_o
);

    state_t            state_q, state_d;
    logic [WW-1:0]     words_q, words_d;
    logic [ST_N-1:0]   status_q, status_d;
    logic              mem_en_q, mem_en_d;
    logic [WIDTH-1:0]  mem_data_q, mem_data_d;
    logic [WIDTH-1:0]  mem_addr_q, mem_addr_d;
    logic              full, accept, run_clr;
    logic              hold_last, exit_seen, exit_settled, exit_hit, timeout_hit;
    logic [CW-1:0]     run_cnt;
    logic              run_max_unused;
    logic [cnt_w(RESET_CYCLES - 1)-1:0]  hold_cnt_unused;
    logic [cnt_w(SETTLE_CYCLES - 1)-1:0] exit_cnt_unused;

    assign full        = words_q == WW'(DEPTH);
    assign in_ready_o  = state_q == LOAD && !full;
    assign accept      = in_valid_i && in_ready_o;
    assign exit_seen   = state_q == RUN && a7_i == WIDTH'(EXIT_A7);
    assign exit_hit    = exit_seen && exit_settled;
    // the edge that brings the run count up to the limit is the timeout edge
    assign timeout_hit = run_cnt == CW'(TIMEOUT_CYCLES - 1);

    // HOLD lasts RESET_CYCLES edges: the counter tops out at RESET_CYCLES-1 on the final one
    sat_counter #(.MAX(RESET_CYCLES - 1)) u_hold (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (state_q != HOLD),
        .inc_i    (state_q == HOLD),
        .count_o  (hold_cnt_unused),
        .at_max_o (hold_last)
    );

    // consecutive exit cycles; the SETTLE_CYCLES-th one completes the exit
    sat_counter #(.MAX(SETTLE_CYCLES - 1)) u_exit (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (!exit_seen),
        .inc_i    (exit_seen),
        .count_o  (exit_cnt_unused),
        .at_max_o (exit_settled)
    );

    // run cycles elapsed, kept through DONE and cleared on a new start
    sat_counter #(.MAX(TIMEOUT_CYCLES)) u_run (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (run_clr),
        .inc_i    (state_q == RUN),
        .count_o  (run_cnt),
        .at_max_o (run_max_unused)
    );

    // next state, preload beat capture and result capture; abort overrides everything
    always_comb begin
        state_d    = state_q;
        words_d    = words_q;
        status_d   = status_q;
        mem_en_d   = 1'b0;
        mem_data_d = mem_data_q;
        mem_addr_d = mem_addr_q;
        run_clr    = 1'b0;
        if (abort_i) begin
            state_d    = IDLE;
            words_d    = '0;
            status_d   = '0;
            mem_data_d = '0;
            mem_addr_d = WIDTH'(BASE_ADDR);
            run_clr    = 1'b1;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        state_d  = LOAD;
                        words_d  = '0;
                        status_d = '0;
                        run_clr  = 1'b1;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        mem_en_d   = 1'b1;
                        mem_data_d = in_data_i;
                        mem_addr_d = WIDTH'(BASE_ADDR) + (WIDTH'(words_q) << 2);
                        words_d    = words_q + 1'b1;
                        state_d    = in_last_i ? HOLD : LOAD;
                    end else if (in_valid_i) begin
                        // only reachable when full: the refused beat ends the load
                        status_d[ST_OVERFLOW] = 1'b1;
                        state_d               = DONE;
                    end
                end
                HOLD: state_d = hold_last ? RUN : HOLD;
                RUN: begin
                    if (exit_hit) begin
                        status_d[ST_PASS] = gp_i == WIDTH'(1) && a0_i == '0;
                        state_d           = DONE;
                    end else if (timeout_hit) begin
                        status_d[ST_TIMEOUT] = 1'b1;
                        state_d              = DONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // state and datapath registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            words_q    <= '0;
            status_q   <= '0;
            mem_en_q   <= 1'b0;
            mem_data_q <= '0;
            mem_addr_q <= WIDTH'(BASE_ADDR);
        end else begin
            state_q    <= state_d;
            words_q    <= words_d;
            status_q   <= status_d;
            mem_en_q   <= mem_en_d;
            mem_data_q <= mem_data_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign cpu_reset_o = state_q != RUN;
    assign done_o      = state_q == DONE;
    assign mem_en_o    = mem_en_q;
    assign mem_data_o  = mem_data_q;
    assign mem_addr_o  = mem_addr_q;
    assign pass_o      = status_q[ST_PASS];
    assign timeout_o   = status_q[ST_TIMEOUT];
    assign overflow_o  = status_q[ST_OVERFLOW];
    assign words_o     = words_q;
    assign cycles_o    = run_cnt;

endmodule

// File: tb/tb_program_harness_ctrl.sv
// tb_program_harness_ctrl: randomized load/run sessions checked through expectation queues
module tb_program_harness_ctrl;

    localparam int DEPTH  = 4;
    localparam int BASE   = 32'h1000;
    localparam int RC     = 2;
    localparam int TO     = 50;
    localparam int EXIT   = 93;
    localparam int SETTLE = 4;

    logic        clk = 0, rst_n = 0, start = 0, abort = 0;
    logic        in_valid = 0, in_last = 0;
    logic [31:0] in_data = 0, gp = 0, a7 = 0, a0 = 0;
    logic        in_ready, cpu_reset, mem_en, done, pass, timeout, overflow;
    logic [31:0] mem_data, mem_addr;
    logic [2:0]  words;
    logic [5:0]  cycles;

    int tests = 0, fails = 0, cyc = 0, nwords = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        bit pass;
        bit timeout;
        bit overflow;
        int words;
        int cycles;
        int cyc;
    } res_t;

    wr_t  wq[$];
    res_t dq[$];
    int   cq[$];
    int   a7v[TO+1], gpv[TO+1], a0v[TO+1];

    program_harness_ctrl #(
        .WIDTH(32), .DEPTH(DEPTH), .BASE_ADDR(BASE), .RESET_CYCLES(RC),
        .TIMEOUT_CYCLES(TO), .EXIT_A7(EXIT), .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
        .in_valid_i(in_valid), .in_data_i(in_data), .in_last_i(in_last),
        .in_ready_o(in_ready), .cpu_reset_o(cpu_reset), .mem_en_o(mem_en),
        .mem_data_o(mem_data), .mem_addr_o(mem_addr),
        .gp_i(gp), .a7_i(a7), .a0_i(a0),
        .done_o(done), .pass_o(pass), .timeout_o(timeout), .overflow_o(overflow),
        .words_o(words), .cycles_o(cycles)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        tests++;
        fails++;
        $display("FAIL %s: DUT event with nothing expected (cycle %0d)", name, cyc);
    endtask

    // Monitor: compares every preload write, run start and result against the queues
    logic prev_cr = 1, prev_done = 0;
    always @(negedge clk) begin
        wr_t w;
        res_t r;
        if (mem_en) begin
            if (wq.size() == 0) unexpected("write");
            else begin
                w = wq.pop_front();
                chk("wr_addr", mem_addr, w.addr);
                chk("wr_data", mem_data, w.data);
            end
        end
        if (prev_cr && !cpu_reset) begin
            if (cq.size() == 0) unexpected("run_start");
            else chk("run_start_cycle", cyc, cq.pop_front());
        end
        if (done && !prev_done) begin
            if (dq.size() == 0) unexpected("done");
            else begin
                r = dq.pop_front();
                chk("done_cycle", cyc, r.cyc);
                chk("pass", pass, r.pass);
                chk("timeout", timeout, r.timeout);
                chk("overflow", overflow, r.overflow);
                chk("words", words, r.words);
                chk("cycles", cycles, r.cycles);
                chk("cpu_reset_in_done", cpu_reset, 1);
            end
        end
        prev_cr   = cpu_reset;
        prev_done = done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle();
        chk("idle_in_ready", in_ready, 0);
        chk("idle_cpu_reset", cpu_reset, 1);
        chk("idle_mem_en", mem_en, 0);
        chk("idle_mem_data", mem_data, 0);
        chk("idle_mem_addr", mem_addr, BASE);
        chk("idle_done", done, 0);
        chk("idle_status", {pass, timeout, overflow}, 0);
        chk("idle_words", words, 0);
        chk("idle_cycles", cycles, 0);
    endtask

    task automatic do_start();
        start = 1;
        tick();
        start = 0;
        nwords = 0;
    endtask

    // Offer one beat after an optional idle gap; the model decides acceptance from its word count
    task automatic beat(input logic [31:0] d, input bit last, output int acc_cyc);
        wr_t  w;
        res_t r;
        repeat ($urandom_range(0, 1)) tick();
        in_valid = 1;
        in_data  = d;
        in_last  = last;
        chk("in_ready", in_ready, nwords < DEPTH);
        if (nwords < DEPTH) begin
            w.addr = BASE + 4 * nwords;
            w.data = d;
            wq.push_back(w);
            nwords++;
        end else begin
            r = '{default: 0};
            r.overflow = 1;
            r.words    = DEPTH;
            r.cyc      = cyc + 1;
            dq.push_back(r);
        end
        acc_cyc = cyc + 1;
        tick();
        in_valid = 0;
        in_last  = 0;
    endtask

    // Run the a7/gp/a0 script through the exit/timeout rules: the exit is the first
    // cycle closing a window of SETTLE exit values; otherwise the run times out
    function automatic res_t predict();
        res_t r = '{default: 0};
        bit   all;
        for (int k = SETTLE; k <= TO; k++) begin
            all = 1;
            for (int j = k - SETTLE + 1; j <= k; j++) if (a7v[j] != EXIT) all = 0;
            if (all) begin
                r.pass   = gpv[k] == 1 && a0v[k] == 0;
                r.cycles = k;
                return r;
            end
        end
        r.timeout = 1;
        r.cycles  = TO;
        return r;
    endfunction

    // 0 random, 1 never settles, 2 exit on the timeout cycle, 3 glitch then pass, 4 exit with a0!=0
    task automatic gen_run(input int mode);
        for (int k = 1; k <= TO; k++) begin
            gpv[k] = ($urandom_range(0, 3) == 0) ? 2 : 1;
            a0v[k] = ($urandom_range(0, 3) == 0) ? 5 : 0;
            case (mode)
                0: a7v[k] = ($urandom_range(0, 3) != 0) ? EXIT : $urandom_range(0, 92);
                1: a7v[k] = ($urandom_range(0, 1) == 1 && k % SETTLE != 0) ? EXIT : 0;
                2: a7v[k] = (k > TO - SETTLE) ? EXIT : 0;
                3: begin a7v[k] = (k == 2) ? 0 : EXIT; gpv[k] = 1; a0v[k] = 0; end
                default: begin a7v[k] = EXIT; gpv[k] = 1; a0v[k] = 5; end
            endcase
        end
    endtask

    // Load n words (last on the final one), then run; stop_at>0 pulls reset mid-run instead
    task automatic session(input int n, input int mode, input bit fixed, input int stop_at);
        int   acc, rs, len;
        res_t r;
        do_start();
        for (int i = 0; i < n; i++) beat(fixed ? 32'h11 * (i + 1) : $urandom, i == n - 1, acc);
        rs = acc + RC;
        cq.push_back(rs);
        gen_run(mode);
        r = predict();
        r.words = n;
        r.cyc   = rs + r.cycles;
        if (stop_at == 0) dq.push_back(r);
        len = (stop_at == 0) ? r.cycles : stop_at;
        while (cyc < rs) tick();
        for (int k = 1; k <= len; k++) begin
            a7 = a7v[k];
            gp = gpv[k];
            a0 = a0v[k];
            tick();
        end
        a7 = 0;
        if (stop_at != 0) begin
            rst_n = 0;
            tick();
            rst_n = 1;
            check_idle();
        end
        tick();
        tick();
    endtask

    task automatic overflow_session(input int n);
        int acc;
        do_start();
        for (int i = 0; i < n; i++) begin
            beat($urandom, 0, acc);
            if (i == DEPTH) break;
        end
        tick();
        tick();
    endtask

    task automatic abort_session();
        int acc;
        do_start();
        beat($urandom, 0, acc);
        beat($urandom, 0, acc);
        abort = 1;
        tick();
        abort = 0;
        check_idle();
    endtask

    initial begin
        tick();
        tick();
        check_idle();
        rst_n = 1;
        tick();
        session(3, 3, 1, 0);
        session(2, 4, 0, 0);
        session(1, 1, 0, 0);
        session(DEPTH, 2, 0, 0);
        overflow_session(DEPTH + 1);
        abort_session();
        session(3, 0, 0, 0);
        session(3, 1, 0, 10);
        session(2, 3, 0, 0);
        for (int i = 0; i < 14; i++) begin
            if ($urandom_range(0, 4) == 0) overflow_session(DEPTH + 1);
            else session($urandom_range(1, DEPTH), $urandom_range(0, 2), 0, 0);
        end
        chk("pending_writes", wq.size(), 0);
        chk("pending_results", dq.size(), 0);
        chk("pending_run_starts", cq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
